// File: rtl/mux_sel_sequencer.sv
// Select-line sequencer for a 2^N:1 mux: scans a channel window,
// streams bits out serially and captures them in par_out. Option: MUX_SEQ_PARITY_EN.
module mux_sel_sequencer #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] first_sel,
  input  logic [N:0]   count,
  output logic [N-1:0] sel,
  input  logic         mux_out,
  output logic         ser_data,
  output logic         ser_valid,
  input  logic         ser_ready,
  output logic         ser_last,
  output logic [2**N-1:0] par_out,
  output logic         busy,
  output logic         done
);

  localparam int M = 2**N;
  localparam logic [N:0] M_W = (N+1)'(M);
  localparam logic [N:0] ONE_W = (N+1)'(1);
  localparam logic [N-1:0] ONE_S = N'(1);

`ifdef MUX_SEQ_PARITY_EN
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCAN   = 2'd1,
    S_DONE   = 2'd2,
    S_PARITY = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;
`endif

  state_t         state_q, state_d;
  logic [N-1:0]   sel_q, sel_d;
  logic [N:0]     rem_q, rem_d;
  logic [M-1:0]   par_q, par_d;
  logic [N:0]     cnt_clamp;
`ifdef MUX_SEQ_PARITY_EN
  logic           acc_q, acc_d;
`endif

  assign cnt_clamp = (count > M_W) ? M_W : count;
  assign sel       = sel_q;
  assign par_out   = par_q;

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      rem_q   <= '0;
      par_q   <= '0;
`ifdef MUX_SEQ_PARITY_EN
      acc_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rem_q   <= rem_d;
      par_q   <= par_d;
`ifdef MUX_SEQ_PARITY_EN
      acc_q   <= acc_d;
`endif
    end
  end

  // Next-state, datapath update and handshake outputs
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    rem_d     = rem_q;
    par_d     = par_q;
`ifdef MUX_SEQ_PARITY_EN
    acc_d     = acc_q;
`endif
    ser_valid = 1'b0;
    ser_data  = 1'b0;
    ser_last  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start && count != '0) begin
          state_d = S_SCAN;
          sel_d   = first_sel;
          rem_d   = cnt_clamp;
          par_d   = '0;
`ifdef MUX_SEQ_PARITY_EN
          acc_d   = 1'b0;
`endif
        end
      end
      S_SCAN: begin
        ser_valid = 1'b1;
        ser_data  = mux_out;
`ifndef MUX_SEQ_PARITY_EN
        ser_last  = (rem_q == ONE_W);
`endif
        if (ser_ready) begin
          par_d[sel_q] = mux_out;
          sel_d        = sel_q + ONE_S;
          rem_d        = rem_q - ONE_W;
`ifdef MUX_SEQ_PARITY_EN
          acc_d        = acc_q ^ mux_out;
          if (rem_q == ONE_W) state_d = S_PARITY;
`else
          if (rem_q == ONE_W) state_d = S_DONE;
`endif
        end
      end
`ifdef MUX_SEQ_PARITY_EN
      S_PARITY: begin
        ser_valid = 1'b1;
        ser_data  = acc_q;
        ser_last  = 1'b1;
        if (ser_ready) state_d = S_DONE;
      end
`endif
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Randomized self-checking bench for mux_sel_sequencer
// with a queue-based scan model and a behavioural mux.
module tb_mux_sel_sequencer;

  localparam int N = 4;
  localparam int M = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  first_sel = '0;
  logic [4:0]  count = '0;
  logic [3:0]  sel;
  logic        mux_out;
  logic        ser_data, ser_valid, ser_last;
  logic        ser_ready = 1'b0;
  logic [15:0] par_out;
  logic        busy, done;
  logic [15:0] mux_in = '0;

  int vectors = 0;
  int miscompares = 0;

  assign mux_out = mux_in[sel];

  always #5 clk = ~clk;

  mux_sel_sequencer #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start),
    .first_sel(first_sel), .count(count),
    .sel(sel), .mux_out(mux_out),
    .ser_data(ser_data), .ser_valid(ser_valid),
    .ser_ready(ser_ready), .ser_last(ser_last),
    .par_out(par_out), .busy(busy), .done(done)
  );

  task automatic test_reset();
    logic [20:0] got;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    got = {sel, par_out, ser_valid};
    vectors++;
    if (got !== 21'd0) begin
      miscompares++;
      $display("FAIL reset sel/par/valid got=%h exp=0", got);
    end
    vectors++;
    if ({busy, done, ser_last, ser_data} !== 4'b0) begin
      miscompares++;
      $display("FAIL reset busy/done/last/data got=%b exp=0000",
               {busy, done, ser_last, ser_data});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // rmode: 0 ready high, 1 random ready, 2 stall 3 cycles on beat 2
  task automatic run_scan(input logic [3:0] f, input logic [4:0] c,
                          input logic [15:0] in, input int rmode,
                          input bit inject, input string name);
    int k, total, beats, stalls, cyc, hold;
    bit got_done;
    logic exp_bits[$];
    logic [15:0] exp_par;
    logic exp_pb;
    logic [7:0] got, exp;
    logic [3:0] end_sel;
    k = (c > 5'd16) ? 16 : int'(c);
    exp_par = '0;
    exp_pb = 1'b0;
    for (int i = 0; i < k; i++) begin
      int ch;
      ch = (int'(f) + i) % M;
      exp_bits.push_back(in[ch]);
      exp_par[ch] = in[ch];
      exp_pb ^= in[ch];
    end
    end_sel = 4'((int'(f) + k) % M);
`ifdef MUX_SEQ_PARITY_EN
    total = k + 1;
`else
    total = k;
`endif
    mux_in = in;
    first_sel = f;
    count = c;
    start = 1'b1;
    beats = 0;
    stalls = 0;
    cyc = 0;
    hold = 0;
    got_done = 1'b0;
    while (!got_done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (inject) begin
        start = 1'($urandom_range(0, 1));
        first_sel = 4'($urandom);
        count = 5'($urandom);
      end
      case (rmode)
        0: ser_ready = 1'b1;
        1: ser_ready = 1'($urandom_range(0, 3) != 0);
        default: begin
          ser_ready = 1'b1;
          if (beats == 1 && hold < 3) begin
            ser_ready = 1'b0;
            hold++;
          end
        end
      endcase
      if (beats < total) begin
        exp[7:5] = 3'b110;
`ifdef MUX_SEQ_PARITY_EN
        exp[4] = (beats == k);
`else
        exp[4] = (beats == k - 1);
`endif
        exp[3:0] = (beats < k) ?
                   4'((int'(f) + beats) % M) : end_sel;
        got = {ser_valid, busy, done, ser_last,
               ser_data, sel[2:0]};
        got[3] = ser_data;
        got[2:0] = 3'b0;
        exp = {exp[7:4],
               (beats < k) ? exp_bits[beats] : exp_pb,
               3'b0};
        vectors++;
        if (got !== exp || sel !== ((beats < k) ?
            4'((int'(f) + beats) % M) : end_sel)) begin
          miscompares++;
          $display("FAIL %s beat%0d v/b/d/l/data got=%b exp=%b sel=%0d",
                   name, beats, got[7:3], exp[7:3], sel);
        end
        if (ser_ready) beats++;
        else stalls++;
      end else begin
        got_done = 1'b1;
        start = 1'b0;
        vectors++;
        if ({ser_valid, busy, done} !== 3'b011 ||
            cyc != total + stalls + 1) begin
          miscompares++;
          $display("FAIL %s done v/b/d got=%b exp=011 cyc=%0d exp=%0d",
                   name, {ser_valid, busy, done}, cyc,
                   total + stalls + 1);
        end
        vectors++;
        if (par_out !== exp_par || sel !== end_sel) begin
          miscompares++;
          $display("FAIL %s par/sel got=%h/%0d exp=%h/%0d",
                   name, par_out, sel, exp_par, end_sel);
        end
      end
    end
    if (!got_done) begin
      vectors++;
      miscompares++;
      $display("FAIL %s timeout no done got=0 exp=1", name);
    end
    @(negedge clk);
    vectors++;
    if ({busy, done, ser_valid} !== 3'b000) begin
      miscompares++;
      $display("FAIL %s idle b/d/v got=%b exp=000",
               name, {busy, done, ser_valid});
    end
  endtask

  task automatic test_count_zero();
    first_sel = 4'd3;
    count = 5'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if ({busy, ser_valid, done} !== 3'b000) begin
        miscompares++;
        $display("FAIL count0 b/v/d got=%b exp=000",
                 {busy, ser_valid, done});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_scan();
    logic [21:0] got;
    mux_in = 16'hFFFF;
    first_sel = 4'd0;
    count = 5'd16;
    ser_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    got = {sel, par_out, ser_valid, busy};
    vectors++;
    if (got !== 22'd0) begin
      miscompares++;
      $display("FAIL rst_mid state got=%h exp=0", got);
    end
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if ({done, busy} !== 2'b00) begin
        miscompares++;
        $display("FAIL rst_mid no_done d/b got=%b exp=00",
                 {done, busy});
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    run_scan(4'd0, 5'd16, 16'hD7A5, 0, 1'b0, "full");
    run_scan(4'd14, 5'd4, 16'h8001, 0, 1'b0, "wrap");
    run_scan(4'd5, 5'd3, 16'hD7A5, 2, 1'b0, "stall");
    test_count_zero();
    run_scan(4'd9, 5'd31, 16'h3C5A, 0, 1'b0, "clamp");
    run_scan(4'd2, 5'd6, 16'h1234, 0, 1'b1, "start_busy");
    run_scan(4'd0, 5'd16, 16'h0001, 0, 1'b0, "one_bit");
    run_scan(4'd15, 5'd1, 16'h8000, 0, 1'b0, "single");
    test_reset_mid_scan();
    run_scan(4'd0, 5'd16, 16'hD7A5, 0, 1'b0, "after_rst");
    for (int i = 0; i < 12; i++) begin
      logic [4:0] c;
      c = 5'($urandom_range(1, 31));
      run_scan(4'($urandom), c, 16'($urandom), 1,
               1'($urandom_range(0, 1)), "random");
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
